apb_master_ctrl: RTL and testbench

- APB initiator that drives the Penable/Pwrite/Pselx/Paddr/Pwdata side of the bridge's APB bus and samples Prdata.
- It is the counterpart of the APB slave-response driver; it serves as the APB back end of the AHB-to-APB bridge.
- Accepts single read/write commands on a valid/ready port, decodes the target slave to a one-hot Pselx, runs the APB setup/enable sequence, and returns one response per command.
- No PREADY: every access takes exactly one SETUP cycle and one ENABLE cycle.

---
 rtl/apb_master_ctrl.sv | 132 +++++++++++++
 tb/tb_apb_master_ctrl.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master_ctrl.sv
// APB initiator: accepts single read/write commands, decodes one of four slave
// windows, runs SETUP/ENABLE (no PREADY) and returns one in-order response per command.
module apb_master_ctrl #(
  parameter int                    ADDR_WIDTH    = 32,
  parameter int                    DATA_WIDTH    = 32,
  parameter logic [ADDR_WIDTH-1:0] SLV_BASE      = 32'h8000_0000,
  parameter int                    SLV_SPAN_LOG2 = 26
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  output logic                  rsp_write,
  output logic                  rsp_err,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  Penable,
  output logic                  Pwrite,
  output logic [3:0]            Pselx,
  output logic [ADDR_WIDTH-1:0] Paddr,
  output logic [DATA_WIDTH-1:0] Pwdata,
  input  logic [DATA_WIDTH-1:0] Prdata
);

  localparam int TAG_LO = SLV_SPAN_LOG2 + 2;

  typedef enum logic [1:0] {IDLE, SETUP, ENABLE, ERR} state_e;

  state_e                state_q, state_d;
  logic                  penable_q, penable_d;
  logic                  pwrite_q, pwrite_d;
  logic [3:0]            psel_q, psel_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic                  err_write_q, err_write_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_write_q, rsp_write_d;
  logic                  rsp_err_q, rsp_err_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;

  logic       accept;
  logic       hit;
  logic [1:0] idx;

  assign cmd_ready = (state_q != SETUP);
  assign accept    = cmd_valid & cmd_ready;
  assign hit       = (cmd_addr[ADDR_WIDTH-1:TAG_LO] == SLV_BASE[ADDR_WIDTH-1:TAG_LO]);
  assign idx       = cmd_addr[SLV_SPAN_LOG2+1:SLV_SPAN_LOG2];

  always_comb begin
    state_d     = state_q;
    pwrite_d    = pwrite_q;
    psel_d      = psel_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    err_write_d = err_write_q;
    case (state_q)
      SETUP: state_d = ENABLE;
      default: begin
        if (accept && hit) begin
          state_d  = SETUP;
          psel_d   = 4'b0001 << idx;
          paddr_d  = cmd_addr;
          pwrite_d = cmd_write;
          pwdata_d = cmd_wdata;
        end else if (accept) begin
          // miss: APB address/data registers keep their last values
          state_d     = ERR;
          psel_d      = 4'b0000;
          err_write_d = cmd_write;
        end else begin
          state_d = IDLE;
          psel_d  = 4'b0000;
        end
      end
    endcase
    penable_d = (state_d == ENABLE);

    rsp_valid_d = (state_q == ENABLE) || (state_q == ERR);
    rsp_err_d   = (state_q == ERR);
    rsp_write_d = 1'b0;
    rsp_rdata_d = '0;
    if (state_q == ENABLE) begin
      rsp_write_d = pwrite_q;
      if (!pwrite_q) rsp_rdata_d = Prdata;
    end else if (state_q == ERR) begin
      rsp_write_d = err_write_q;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      psel_q      <= 4'b0000;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      err_write_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      psel_q      <= psel_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      err_write_q <= err_write_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_write_q <= rsp_write_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign Penable   = penable_q;
  assign Pwrite    = pwrite_q;
  assign Pselx     = psel_q;
  assign Paddr     = paddr_q;
  assign Pwdata    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_write = rsp_write_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_apb_master_ctrl.sv
// Bench for apb_master_ctrl: scenario tasks check APB timing inline; a response
// monitor pops expected responses from a scoreboard queue filled at command acceptance.
module tb_apb_master_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic        rsp_valid, rsp_write, rsp_err;
  logic [31:0] rsp_rdata;
  logic        Penable, Pwrite;
  logic [3:0]  Pselx;
  logic [31:0] Paddr, Pwdata;
  logic [31:0] Prdata = 32'hA5A5_A5A5;

  typedef struct packed {
    logic        write;
    logic        err;
    logic [31:0] rdata;
  } rsp_t;

  rsp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  apb_master_ctrl dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_write(rsp_write), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
    .Penable(Penable), .Pwrite(Pwrite), .Pselx(Pselx), .Paddr(Paddr), .Pwdata(Pwdata),
    .Prdata(Prdata)
  );

  always #5 clock = ~clock;

  // response scoreboard and bus invariants, sampled mid-cycle
  always @(negedge clock) begin
    if (!reset) begin
      n_checks++;
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL rsp_unexpected: got write=%0b err=%0b rdata=%h, expected no response",
                   rsp_write, rsp_err, rsp_rdata);
        end else begin
          rsp_t e;
          e = exp_q.pop_front();
          if ({rsp_write, rsp_err, rsp_rdata} !== e) begin
            n_fail++;
            $display("FAIL rsp_fields: got write=%0b err=%0b rdata=%h, expected write=%0b err=%0b rdata=%h",
                     rsp_write, rsp_err, rsp_rdata, e.write, e.err, e.rdata);
          end
        end
      end else if ({rsp_write, rsp_err, rsp_rdata} !== 34'd0) begin
        n_fail++;
        $display("FAIL rsp_idle_zero: got write=%0b err=%0b rdata=%h, expected all 0",
                 rsp_write, rsp_err, rsp_rdata);
      end
      n_checks++;
      if (($countones(Pselx) > 1) || (Penable && Pselx == 4'd0)) begin
        n_fail++;
        $display("FAIL apb_invariant: got Pselx=%b Penable=%0b, expected Pselx 0/one-hot and Penable->Pselx",
                 Pselx, Penable);
      end
    end
  end

  task automatic drive_cmd(input logic wr, input logic [31:0] a, input logic [31:0] d);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = a;
    cmd_wdata = d;
  endtask

  task automatic test_reset;
    #2;
    n_checks++;
    if ({Penable, Pwrite, Pselx, Paddr, Pwdata, rsp_valid, rsp_write, rsp_err, rsp_rdata, cmd_ready}
        !== {1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_state: got Pen=%0b Pwr=%0b Psel=%b Paddr=%h Pwdata=%h rv=%0b rw=%0b re=%0b rd=%h rdy=%0b, expected all 0 with cmd_ready=1",
               Penable, Pwrite, Pselx, Paddr, Pwdata, rsp_valid, rsp_write, rsp_err, rsp_rdata, cmd_ready);
    end
    @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);
  endtask

  task automatic test_write_hit;
    drive_cmd(1'b1, 32'h8000_0010, 32'hDEAD_BEEF);
    exp_q.push_back('{1'b1, 1'b0, 32'd0});
    @(posedge clock); #1 cmd_valid = 1'b0;
    @(negedge clock); // t0+1 SETUP
    n_checks++;
    if ({Pselx, Penable, Paddr, Pwdata, Pwrite, cmd_ready} !== {4'b0001, 1'b0, 32'h8000_0010, 32'hDEAD_BEEF, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL wr_setup: got Psel=%b Pen=%0b Paddr=%h Pwdata=%h Pwr=%0b rdy=%0b, expected 0001 0 80000010 deadbeef 1 0",
               Pselx, Penable, Paddr, Pwdata, Pwrite, cmd_ready);
    end
    @(negedge clock); // t0+2 ENABLE
    n_checks++;
    if ({Pselx, Penable, Paddr, Pwdata} !== {4'b0001, 1'b1, 32'h8000_0010, 32'hDEAD_BEEF}) begin
      n_fail++;
      $display("FAIL wr_enable: got Psel=%b Pen=%0b Paddr=%h Pwdata=%h, expected 0001 1 80000010 deadbeef",
               Pselx, Penable, Paddr, Pwdata);
    end
    @(negedge clock); // t0+3
    n_checks++;
    if (rsp_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL wr_rsp_latency: got rsp_valid=%0b, expected 1", rsp_valid);
    end
    @(negedge clock); // t0+4
    n_checks++;
    if ({Pselx, Penable, rsp_valid} !== 6'd0) begin
      n_fail++;
      $display("FAIL wr_idle: got Psel=%b Pen=%0b rv=%0b, expected 0000 0 0", Pselx, Penable, rsp_valid);
    end
  endtask

  task automatic test_read_hit;
    drive_cmd(1'b0, 32'h8C00_0004, 32'h0);
    exp_q.push_back('{1'b0, 1'b0, 32'h1234_5678});
    @(posedge clock); #1 cmd_valid = 1'b0;
    @(negedge clock);
    n_checks++;
    if ({Pselx, Penable, Pwrite, Paddr} !== {4'b1000, 1'b0, 1'b0, 32'h8C00_0004}) begin
      n_fail++;
      $display("FAIL rd_setup: got Psel=%b Pen=%0b Pwr=%0b Paddr=%h, expected 1000 0 0 8c000004",
               Pselx, Penable, Pwrite, Paddr);
    end
    @(negedge clock);
    n_checks++;
    if ({Pselx, Penable} !== {4'b1000, 1'b1}) begin
      n_fail++;
      $display("FAIL rd_enable: got Psel=%b Pen=%0b, expected 1000 1", Pselx, Penable);
    end
    Prdata = 32'h1234_5678;
    @(posedge clock); #1 Prdata = 32'hA5A5_A5A5;
    @(negedge clock);
    n_checks++;
    if ({rsp_valid, rsp_rdata} !== {1'b1, 32'h1234_5678}) begin
      n_fail++;
      $display("FAIL rd_rsp: got rv=%0b rdata=%h, expected 1 12345678", rsp_valid, rsp_rdata);
    end
  endtask

  task automatic test_back_to_back;
    logic [3:0] exp_sel [4] = '{4'b0010, 4'b0010, 4'b0100, 4'b0100};
    logic       exp_en  [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic       exp_rv  [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    drive_cmd(1'b1, 32'h8400_0000, 32'h5555_AAAA);
    exp_q.push_back('{1'b1, 1'b0, 32'd0});
    @(posedge clock);
    for (int c = 0; c < 6; c++) begin
      @(negedge clock);
      if (c < 4) begin
        n_checks++;
        if ({Pselx, Penable, cmd_ready} !== {exp_sel[c], exp_en[c], exp_en[c]}) begin
          n_fail++;
          $display("FAIL b2b_cycle%0d: got Psel=%b Pen=%0b rdy=%0b, expected %b %0b %0b",
                   c, Pselx, Penable, cmd_ready, exp_sel[c], exp_en[c], exp_en[c]);
        end
      end
      n_checks++;
      if (rsp_valid !== exp_rv[c]) begin
        n_fail++;
        $display("FAIL b2b_rsp_cycle%0d: got rv=%0b, expected %0b", c, rsp_valid, exp_rv[c]);
      end
      if (c == 0) drive_cmd(1'b0, 32'h8800_0000, 32'h0);
      if (c == 1) exp_q.push_back('{1'b0, 1'b0, 32'hCAFE_F00D});
      if (c == 2) cmd_valid = 1'b0;
      if (c == 3) Prdata = 32'hCAFE_F00D;
      if (c == 4) Prdata = 32'hA5A5_A5A5;
    end
  endtask

  task automatic test_decode_miss;
    drive_cmd(1'b0, 32'h9000_0000, 32'h0);
    exp_q.push_back('{1'b0, 1'b1, 32'd0});
    @(posedge clock);
    @(negedge clock); // ERR
    n_checks++;
    if ({Pselx, Penable, cmd_ready, Paddr} !== {4'b0000, 1'b0, 1'b1, 32'h8800_0000}) begin
      n_fail++;
      $display("FAIL miss_err: got Psel=%b Pen=%0b rdy=%0b Paddr=%h, expected 0000 0 1 88000000",
               Pselx, Penable, cmd_ready, Paddr);
    end
    drive_cmd(1'b1, 32'h8000_0000, 32'h0BAD_F00D);
    exp_q.push_back('{1'b1, 1'b0, 32'd0});
    @(posedge clock); #1 cmd_valid = 1'b0;
    @(negedge clock); // error response + SETUP of hit
    n_checks++;
    if ({rsp_valid, rsp_err, Pselx, Penable, Paddr} !== {1'b1, 1'b1, 4'b0001, 1'b0, 32'h8000_0000}) begin
      n_fail++;
      $display("FAIL miss_rsp_then_setup: got rv=%0b re=%0b Psel=%b Pen=%0b Paddr=%h, expected 1 1 0001 0 80000000",
               rsp_valid, rsp_err, Pselx, Penable, Paddr);
    end
    @(negedge clock);
    n_checks++;
    if ({Penable, Pwdata} !== {1'b1, 32'h0BAD_F00D}) begin
      n_fail++;
      $display("FAIL miss_next_enable: got Pen=%0b Pwdata=%h, expected 1 0badf00d", Penable, Pwdata);
    end
    repeat (2) @(negedge clock);
  endtask

  task automatic test_reset_mid_op;
    drive_cmd(1'b0, 32'h8C00_0008, 32'h0);
    @(posedge clock); #1 cmd_valid = 1'b0;
    @(negedge clock);
    @(negedge clock); // ENABLE
    n_checks++;
    if (Penable !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_pre_enable: got Pen=%0b, expected 1", Penable);
    end
    Prdata = 32'h7777_7777;
    #1 reset = 1'b1;
    #1;
    n_checks++;
    if ({Pselx, Penable, rsp_valid, cmd_ready} !== {4'b0000, 1'b0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL rst_async: got Psel=%b Pen=%0b rv=%0b rdy=%0b, expected 0000 0 0 1",
               Pselx, Penable, rsp_valid, cmd_ready);
    end
    @(negedge clock);
    reset = 1'b0;
    Prdata = 32'hA5A5_A5A5;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      n_checks++;
      if ({rsp_valid, cmd_ready} !== 2'b01) begin
        n_fail++;
        $display("FAIL rst_no_rsp_cycle%0d: got rv=%0b rdy=%0b, expected 0 1", c, rsp_valid, cmd_ready);
      end
    end
    drive_cmd(1'b0, 32'h8400_0020, 32'h0);
    exp_q.push_back('{1'b0, 1'b0, 32'h3C3C_1234});
    @(posedge clock); #1 cmd_valid = 1'b0;
    @(negedge clock);
    n_checks++;
    if ({Pselx, Paddr} !== {4'b0010, 32'h8400_0020}) begin
      n_fail++;
      $display("FAIL rst_next_setup: got Psel=%b Paddr=%h, expected 0010 84000020", Pselx, Paddr);
    end
    @(negedge clock);
    Prdata = 32'h3C3C_1234;
    @(negedge clock);
    n_checks++;
    if ({rsp_valid, rsp_rdata} !== {1'b1, 32'h3C3C_1234}) begin
      n_fail++;
      $display("FAIL rst_next_rsp: got rv=%0b rdata=%h, expected 1 3c3c1234", rsp_valid, rsp_rdata);
    end
    Prdata = 32'hA5A5_A5A5;
    repeat (2) @(negedge clock);
  endtask

  initial begin
    test_reset();
    test_write_hit();
    test_read_hit();
    test_back_to_back();
    test_decode_miss();
    test_reset_mid_op();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL rsp_missing: got %0d responses outstanding, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
